// File: rtl/up_count_sequencer_if.sv
// Handshake and data bundle between a controller and the up-count sequencer.
// The controller drives the request/configuration side; the sequencer drives
// the registered count and status side.
interface up_count_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             GO;
    logic             CLR;
    logic             EN;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] LIMIT;
    logic [WIDTH-1:0] Q;
    logic             BUSY;
    logic             DONE;
    logic             TC;
    logic             ERR;

    modport master (
        output GO, CLR, EN, D, LIMIT,
        input  Q, BUSY, DONE, TC, ERR
    );

    modport slave (
        input  GO, CLR, EN, D, LIMIT,
        output Q, BUSY, DONE, TC, ERR
    );
endinterface

// File: rtl/up_count_sequencer.sv
// Loadable up-counter with a GO/DONE handshake. A start value and a limit are
// captured on an accepted GO; the count then advances by one on each enabled
// cycle until it equals the limit, where it parks in DONE until restarted or
// cleared. Every output comes straight from a flop.
module up_count_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    up_count_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tc_q, tc_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] q_inc;

    // The increment only matters in RUN, where q_q < lim_q, so it never wraps.
    assign q_inc = q_q + WIDTH'(1);

    // State, count, captured limit and output flags; all cleared by reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            lim_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tc_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            lim_q   <= lim_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tc_q    <= tc_d;
            err_q   <= err_d;
        end
    end

    // Next-state and next-output decode: CLR beats GO, GO beats EN.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        lim_d   = lim_q;
        err_d   = err_q;
        tc_d    = 1'b0;

        if (bus.CLR) begin
            state_d = ST_IDLE;
            q_d     = '0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.GO) begin
                        lim_d = bus.LIMIT;
                        err_d = 1'b0;
                        if (bus.D > bus.LIMIT) begin
                            // Bad start value: flag it, leave Q alone, go idle.
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else if (bus.D == bus.LIMIT) begin
                            // Nothing to count; land in DONE immediately.
                            q_d     = bus.D;
                            state_d = ST_DONE;
                            tc_d    = 1'b1;
                        end else begin
                            q_d     = bus.D;
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // GO is ignored here: no mid-run restart or resampling.
                    if (bus.EN) begin
                        q_d = q_inc;
                        if (q_inc == lim_q) begin
                            state_d = ST_DONE;
                            tc_d    = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Status levels follow the state being entered so they stay registered.
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    assign bus.Q    = q_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.TC   = tc_q;
    assign bus.ERR  = err_q;

endmodule

// File: tb/tb_up_count_sequencer.sv
// Directed bench for up_count_sequencer at WIDTH=8 with hand-computed
// expectations for each step.
module tb_up_count_sequencer;

    localparam int W = 8;

    logic CLK;
    logic RST_N;
    int   passed;
    int   total;

    up_count_sequencer_if #(.WIDTH(W)) bus ();

    up_count_sequencer #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [W-1:0] q, input logic busy,
                             input logic done, input logic tc, input logic err);
        check({tag, ".Q"},    {24'd0, bus.Q}, {24'd0, q});
        check({tag, ".BUSY"}, {31'd0, bus.BUSY}, {31'd0, busy});
        check({tag, ".DONE"}, {31'd0, bus.DONE}, {31'd0, done});
        check({tag, ".TC"},   {31'd0, bus.TC},   {31'd0, tc});
        check({tag, ".ERR"},  {31'd0, bus.ERR},  {31'd0, err});
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        RST_N     = 1'b0;
        bus.GO    = 1'b0;
        bus.CLR   = 1'b0;
        bus.EN    = 1'b0;
        bus.D     = '0;
        bus.LIMIT = '0;

        step();
        step();
        check_all("reset", 8'd0, 0, 0, 0, 0);
        RST_N = 1'b1;

        // Reset mid-run
        bus.D = 8'd3; bus.LIMIT = 8'd10; bus.GO = 1'b1;
        step();
        check_all("mr_load", 8'd3, 1, 0, 0, 0);
        bus.GO = 1'b0; bus.EN = 1'b1;
        step();
        step();
        check_all("mr_q5", 8'd5, 1, 0, 0, 0);
        #2 RST_N = 1'b0;
        #1;
        check_all("mr_async", 8'd0, 0, 0, 0, 0);
        #2 RST_N = 1'b1;
        step();
        step();
        check_all("mr_idle_en", 8'd0, 0, 0, 0, 0);

        // Basic count 3..7 with EN held high
        bus.D = 8'd3; bus.LIMIT = 8'd7; bus.GO = 1'b1; bus.EN = 1'b1;
        step();
        check_all("bc_3", 8'd3, 1, 0, 0, 0);
        bus.GO = 1'b0;
        step();
        check_all("bc_4", 8'd4, 1, 0, 0, 0);
        step();
        check_all("bc_5", 8'd5, 1, 0, 0, 0);
        step();
        check_all("bc_6", 8'd6, 1, 0, 0, 0);
        step();
        check_all("bc_7", 8'd7, 0, 1, 1, 0);
        step();
        check_all("bc_hold", 8'd7, 0, 1, 0, 0);

        // Restart from DONE
        bus.D = 8'd2; bus.LIMIT = 8'd3; bus.GO = 1'b1; bus.EN = 1'b0;
        step();
        check_all("rs_load", 8'd2, 1, 0, 0, 0);
        bus.GO = 1'b0; bus.EN = 1'b1;
        step();
        check_all("rs_done", 8'd3, 0, 1, 1, 0);

        // EN gaps with GO pulsed mid-run
        bus.D = 8'd0; bus.LIMIT = 8'd4; bus.GO = 1'b1; bus.EN = 1'b0;
        step();
        check_all("gap_load", 8'd0, 1, 0, 0, 0);
        bus.GO = 1'b0; bus.EN = 1'b1;
        step();
        check_all("gap_e1", 8'd1, 1, 0, 0, 0);
        bus.EN = 1'b0;
        step();
        check_all("gap_n1", 8'd1, 1, 0, 0, 0);
        bus.EN = 1'b1; bus.GO = 1'b1; bus.D = 8'd9; bus.LIMIT = 8'd20;
        step();
        check_all("gap_e2go", 8'd2, 1, 0, 0, 0);
        bus.EN = 1'b0; bus.GO = 1'b0;
        step();
        check_all("gap_n2", 8'd2, 1, 0, 0, 0);
        bus.EN = 1'b1;
        step();
        check_all("gap_e3", 8'd3, 1, 0, 0, 0);
        bus.EN = 1'b0;
        step();
        check_all("gap_n3", 8'd3, 1, 0, 0, 0);
        bus.EN = 1'b1;
        step();
        check_all("gap_e4", 8'd4, 0, 1, 1, 0);

        // Boundaries: D == LIMIT at the top of the range
        bus.EN = 1'b0; bus.D = 8'hFF; bus.LIMIT = 8'hFF; bus.GO = 1'b1;
        step();
        check_all("bd_eq", 8'hFF, 0, 1, 1, 0);
        bus.GO = 1'b0;
        step();
        check_all("bd_eq_hold", 8'hFF, 0, 1, 0, 0);
        // D > LIMIT raises ERR and leaves Q untouched
        bus.D = 8'd9; bus.LIMIT = 8'd5; bus.GO = 1'b1;
        step();
        check_all("bd_err", 8'hFF, 0, 0, 0, 1);
        bus.GO = 1'b0; bus.EN = 1'b1;
        step();
        check_all("bd_err_sticky", 8'hFF, 0, 0, 0, 1);
        // A good GO clears ERR
        bus.D = 8'd1; bus.LIMIT = 8'd2; bus.GO = 1'b1; bus.EN = 1'b0;
        step();
        check_all("bd_ok_load", 8'd1, 1, 0, 0, 0);
        bus.GO = 1'b0; bus.EN = 1'b1;
        step();
        check_all("bd_ok_done", 8'd2, 0, 1, 1, 0);

        // CLR beats GO and EN
        bus.D = 8'd3; bus.LIMIT = 8'd10; bus.GO = 1'b1; bus.EN = 1'b0;
        step();
        bus.GO = 1'b0; bus.EN = 1'b1;
        step();
        step();
        check_all("clr_pre", 8'd5, 1, 0, 0, 0);
        bus.CLR = 1'b1; bus.GO = 1'b1; bus.D = 8'd8; bus.LIMIT = 8'd9;
        step();
        check_all("clr_hit", 8'd0, 0, 0, 0, 0);
        bus.CLR = 1'b0; bus.GO = 1'b0;
        step();
        check_all("clr_idle", 8'd0, 0, 0, 0, 0);

        // CLR also drops a sticky ERR
        bus.EN = 1'b0; bus.D = 8'd9; bus.LIMIT = 8'd5; bus.GO = 1'b1;
        step();
        check_all("clr_err_set", 8'd0, 0, 0, 0, 1);
        bus.GO = 1'b0; bus.CLR = 1'b1;
        step();
        check_all("clr_err_clr", 8'd0, 0, 0, 0, 0);
        bus.CLR = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
